// File: rtl/qpi_flash_pkg.sv
// rtl/qpi_flash_pkg.sv - shared types and widths for the qpi_flash arbiter slice
//
// Purpose: arbiter FSM state encoding, bus widths and the requester port index.
// Ports:   none (package).

package qpi_flash_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_PT_ENTER,
    ST_PASS,
    ST_PT_EXIT
  } state_e;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_idx_e;

endpackage

// File: rtl/qpi_flash_rr_select.sv
// rtl/qpi_flash_rr_select.sv - two-port priority selector with starvation counter
//
// Purpose: picks port 0 by default; port 1 is forced after STARVE_LIMIT
//          consecutive port-0 grants taken while port 1 was waiting.
// Ports:
//   clk, reset_wait_finished  clock, asynchronous active-high reset
//   req_i[1:0]                port requests (bit n = port n)
//   grant_en_i                the arbitration result is being consumed this cycle
//   grant_idx_o               winning port
//   grant_valid_o             at least one port is requesting

module qpi_flash_rr_select
  import qpi_flash_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_wait_finished,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output port_idx_e  grant_idx_o,
  output logic       grant_valid_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       force_port1;

  always_comb begin
    grant_valid_o = |req_i;
    force_port1   = req_i[1] && (!req_i[0] || (starve_q >= LIMIT));
    grant_idx_o   = force_port1 ? PORT_1 : PORT_0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!req_i[1]) begin
      starve_d = 4'd0;
    end else if (grant_en_i && grant_valid_o) begin
      if (grant_idx_o == PORT_1) begin
        starve_d = 4'd0;
      end else if (starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_wait_finished) begin
    if (reset_wait_finished) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/qpi_flash_arbiter.sv
// rtl/qpi_flash_arbiter.sv - shares one qpi_flash read engine between two readers and a passthrough
//
// Purpose: arbitrates CPU ROM window (port 0), background copier (port 1) and the
//          host programmer passthrough onto one qpi_flash engine, with a
//          one-entry last-byte cache.
// Ports:
//   clk, reset_wait_finished      clock, asynchronous active-high reset
//   req0_i/addr0_i/ack0_o/data0_o port 0 byte-read handshake
//   req1_i/addr1_i/ack1_o/data1_o port 1 byte-read handshake
//   pt_req_i, pt_gnt_o            passthrough session request / grant
//   flash_ready_i                 engine ready
//   flash_read_o, flash_addr_o    one-cycle read strobe and registered address
//   flash_data_i                  engine read data
//   flash_passthrough_o           engine passthrough enable

module qpi_flash_arbiter
  import qpi_flash_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset_wait_finished,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] data0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] data1_o,
  input  logic              pt_req_i,
  output logic              pt_gnt_o,
  input  logic              flash_ready_i,
  output logic              flash_read_o,
  output logic [ADDR_W-1:0] flash_addr_o,
  input  logic [DATA_W-1:0] flash_data_i,
  output logic              flash_passthrough_o
);

  localparam int            TW      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_END = TW'(BUSY_TIMEOUT - 1);

  state_e            state_q, state_d;
  port_idx_e         gnt_q, gnt_d;
  logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
  logic [TW-1:0]     busy_cnt_q, busy_cnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_W-1:0] cache_data_q, cache_data_d;
  logic              flash_read_q, flash_read_d;
  logic              flash_pt_q, flash_pt_d;
  logic              pt_gnt_q, pt_gnt_d;

  port_idx_e         sel_idx;
  logic              sel_valid;
  logic              idle_eval;
  logic              grant_en;
  logic [ADDR_W-1:0] sel_addr;
  logic              cache_hit;

  // Requests are only looked at in IDLE with the engine ready and no ack on
  // the outputs; the ack cycle is a dead cycle so the acked requester can drop
  // its req before it is sampled again.
  assign idle_eval = (state_q == ST_IDLE) && flash_ready_i && !ack0_q && !ack1_q;
  assign grant_en  = idle_eval && !pt_req_i;
  assign sel_addr  = (sel_idx == PORT_1) ? addr1_i : addr0_i;
  assign cache_hit = cache_valid_q && (sel_addr == cache_addr_q);

  qpi_flash_rr_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_rr_select (
    .clk                (clk),
    .reset_wait_finished(reset_wait_finished),
    .req_i              ({req1_i, req0_i}),
    .grant_en_i         (grant_en),
    .grant_idx_o        (sel_idx),
    .grant_valid_o      (sel_valid)
  );

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    flash_addr_d  = flash_addr_q;
    busy_cnt_d    = busy_cnt_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    data0_d       = data0_q;
    data1_d       = data1_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;

    case (state_q)
      ST_IDLE: begin
        if (idle_eval) begin
          if (pt_req_i) begin
            state_d = ST_PT_ENTER;
          end else if (sel_valid) begin
            gnt_d = sel_idx;
            if (cache_hit) begin
              state_d = ST_HIT;
            end else begin
              state_d      = ST_ISSUE;
              flash_addr_d = sel_addr;
            end
          end
        end
      end
      ST_HIT: begin
        if (gnt_q == PORT_1) begin
          ack1_d  = 1'b1;
          data1_d = cache_data_q;
        end else begin
          ack0_d  = 1'b1;
          data0_d = cache_data_q;
        end
        state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        busy_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // An engine that never signals busy is treated as done after the timeout.
        if (!flash_ready_i || (busy_cnt_q == CNT_END)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (flash_ready_i) begin
          if (gnt_q == PORT_1) begin
            ack1_d  = 1'b1;
            data1_d = flash_data_i;
          end else begin
            ack0_d  = 1'b1;
            data0_d = flash_data_i;
          end
          cache_valid_d = 1'b1;
          cache_addr_d  = flash_addr_q;
          cache_data_d  = flash_data_i;
          state_d       = ST_IDLE;
        end
      end
      ST_PT_ENTER: state_d = ST_PASS;
      ST_PASS: begin
        if (!pt_req_i) begin
          state_d = ST_PT_EXIT;
        end
      end
      ST_PT_EXIT: begin
        // The programmer may have rewritten the cached byte.
        cache_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Engine-side controls are registered from the next state so each one
    // lines up with the state it belongs to; passthrough leads pt_gnt on entry
    // and trails it on exit by one cycle.
    flash_read_d = (state_d == ST_ISSUE);
    flash_pt_d   = (state_d == ST_PT_ENTER) || (state_d == ST_PASS) || (state_d == ST_PT_EXIT);
    pt_gnt_d     = (state_d == ST_PASS);
  end

  always_ff @(posedge clk or posedge reset_wait_finished) begin
    if (reset_wait_finished) begin
      state_q       <= ST_IDLE;
      gnt_q         <= PORT_0;
      flash_addr_q  <= '0;
      busy_cnt_q    <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      data0_q       <= '0;
      data1_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
      flash_read_q  <= 1'b0;
      flash_pt_q    <= 1'b0;
      pt_gnt_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      flash_addr_q  <= flash_addr_d;
      busy_cnt_q    <= busy_cnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
      flash_read_q  <= flash_read_d;
      flash_pt_q    <= flash_pt_d;
      pt_gnt_q      <= pt_gnt_d;
    end
  end

  assign ack0_o              = ack0_q;
  assign ack1_o              = ack1_q;
  assign data0_o             = data0_q;
  assign data1_o             = data1_q;
  assign pt_gnt_o            = pt_gnt_q;
  assign flash_read_o        = flash_read_q;
  assign flash_addr_o        = flash_addr_q;
  assign flash_passthrough_o = flash_pt_q;

endmodule

// File: tb/tb_qpi_flash_arbiter.sv
// tb/tb_qpi_flash_arbiter.sv - directed self-checking bench for qpi_flash_arbiter

module tb_qpi_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, pt_req = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic        ack0, ack1, pt_gnt, flash_read, flash_pt;
  logic [7:0]  data0, data1;
  logic [23:0] flash_addr;
  logic        flash_ready = 1'b1;
  logic [7:0]  flash_data = '0;

  int          checks = 0;
  int          fails = 0;
  logic        model_timeout = 1'b0;
  logic [7:0]  model_data = '0;
  int          model_left = 0;

  always #5 clk = ~clk;

  qpi_flash_arbiter #(.STARVE_LIMIT(4), .BUSY_TIMEOUT(8)) dut (
    .clk                (clk),
    .reset_wait_finished(rst),
    .req0_i             (req0),
    .addr0_i            (addr0),
    .ack0_o             (ack0),
    .data0_o            (data0),
    .req1_i             (req1),
    .addr1_i            (addr1),
    .ack1_o             (ack1),
    .data1_o            (data1),
    .pt_req_i           (pt_req),
    .pt_gnt_o           (pt_gnt),
    .flash_ready_i      (flash_ready),
    .flash_read_o       (flash_read),
    .flash_addr_o       (flash_addr),
    .flash_data_i       (flash_data),
    .flash_passthrough_o(flash_pt)
  );

  // Engine model: after a strobe, ready is low for 3 cycles, then returns with
  // model_data. In timeout mode it ignores strobes and keeps ready high.
  always @(negedge clk) begin
    if (rst) begin
      flash_ready = 1'b1;
      model_left  = 0;
    end else if (model_timeout) begin
      flash_data = model_data;
    end else if (model_left > 0) begin
      model_left--;
      if (model_left == 0) begin
        flash_ready = 1'b1;
        flash_data  = model_data;
      end
    end else if (flash_read) begin
      flash_ready = 1'b0;
      flash_data  = 8'h00;
      model_left  = 3;
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin fails++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin fails++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL reset_data0: got %h want 00", data0); end
    checks++; if (data1 !== 8'h00) begin fails++; $display("FAIL reset_data1: got %h want 00", data1); end
    checks++; if (pt_gnt !== 1'b0) begin fails++; $display("FAIL reset_pt_gnt: got %b want 0", pt_gnt); end
    checks++; if (flash_read !== 1'b0) begin fails++; $display("FAIL reset_flash_read: got %b want 0", flash_read); end
    checks++; if (flash_addr !== 24'h0) begin fails++; $display("FAIL reset_flash_addr: got %h want 000000", flash_addr); end
    checks++; if (flash_pt !== 1'b0) begin fails++; $display("FAIL reset_passthrough: got %b want 0", flash_pt); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read;
    int   cyc = 0;
    logic got = 1'b0, a1 = 1'b0;
    model_data = 8'hAB; addr0 = 24'h123454; req0 = 1'b1;
    @(negedge clk);
    checks++; if (flash_read !== 1'b1) begin fails++; $display("FAIL single_strobe: got %b want 1", flash_read); end
    checks++; if (flash_addr !== 24'h123454) begin fails++; $display("FAIL single_addr: got %h want 123454", flash_addr); end
    while (!got && cyc < 50) begin
      @(negedge clk); cyc++;
      if (ack1) a1 = 1'b1;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    checks++; if (!got || cyc != 4) begin fails++; $display("FAIL single_latency: got %0d (ack %b) want 4", cyc, got); end
    checks++; if (data0 !== 8'hAB) begin fails++; $display("FAIL single_data0: got %h want ab", data0); end
    checks++; if (a1 !== 1'b0) begin fails++; $display("FAIL single_ack1: got %b want 0", a1); end
  endtask

  task automatic test_cache_hit;
    int   cyc = 0;
    logic got = 1'b0, fr = 1'b0;
    repeat (2) @(negedge clk);
    addr0 = 24'h123454; req0 = 1'b1;
    while (!got && cyc < 20) begin
      @(negedge clk); cyc++;
      if (flash_read) fr = 1'b1;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    checks++; if (!got || cyc != 2) begin fails++; $display("FAIL hit_latency: got %0d (ack %b) want 2", cyc, got); end
    checks++; if (data0 !== 8'hAB) begin fails++; $display("FAIL hit_data0: got %h want ab", data0); end
    checks++; if (fr !== 1'b0) begin fails++; $display("FAIL hit_no_strobe: got %b want 0", fr); end
  endtask

  task automatic test_starvation;
    int   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int   order[10];
    int   n = 0, cyc = 0;
    logic ov = 1'b0;
    for (int i = 0; i < 10; i++) order[i] = -1;
    repeat (2) @(negedge clk);
    model_data = 8'h5A; addr0 = 24'h000010; addr1 = 24'h000020;
    req0 = 1'b1; req1 = 1'b1;
    while (n < 10 && cyc < 600) begin
      @(negedge clk); cyc++;
      if (ack0 && ack1) ov = 1'b1;
      if (ack0) begin order[n] = 0; n++; end
      else if (ack1) begin order[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n != 10) begin fails++; $display("FAIL starve_count: got %0d acks want 10", n); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin fails++; $display("FAIL starve_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
    end
    checks++; if (ov !== 1'b0) begin fails++; $display("FAIL starve_dual_ack: got %b want 0", ov); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_passthrough_during_read;
    int   cyc = 0;
    logic got = 1'b0, seen = 1'b0, fr = 1'b0;
    repeat (2) @(negedge clk);
    model_data = 8'h5F; addr0 = 24'h000005; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pt_req = 1'b1;
    while (!got && cyc < 30) begin
      @(negedge clk); cyc++;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    checks++; if (!got || data0 !== 8'h5F) begin fails++; $display("FAIL pt_read_first: ack %b data %h want ack 1 data 5f", got, data0); end
    checks++; if (flash_pt !== 1'b0) begin fails++; $display("FAIL pt_not_during_ack: got %b want 0", flash_pt); end
    cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk); cyc++;
      if (flash_read) fr = 1'b1;
      if (flash_pt) seen = 1'b1;
    end
    checks++; if (!seen || pt_gnt !== 1'b0) begin fails++; $display("FAIL pt_enter: passthrough %b pt_gnt %b want 1 0", seen, pt_gnt); end
    checks++; if (fr !== 1'b0) begin fails++; $display("FAIL pt_no_strobe: got %b want 0", fr); end
    @(negedge clk);
    checks++; if (pt_gnt !== 1'b1 || flash_pt !== 1'b1) begin fails++; $display("FAIL pt_gnt_on: pt_gnt %b passthrough %b want 1 1", pt_gnt, flash_pt); end
    repeat (3) @(negedge clk);
    pt_req = 1'b0;
    @(negedge clk);
    checks++; if (pt_gnt !== 1'b0 || flash_pt !== 1'b1) begin fails++; $display("FAIL pt_gnt_off: pt_gnt %b passthrough %b want 0 1", pt_gnt, flash_pt); end
    @(negedge clk);
    checks++; if (flash_pt !== 1'b0) begin fails++; $display("FAIL pt_release: got %b want 0", flash_pt); end
    req0 = 1'b1;
    @(negedge clk);
    checks++; if (flash_read !== 1'b1 || flash_addr !== 24'h000005) begin fails++; $display("FAIL pt_cache_flushed: strobe %b addr %h want 1 000005", flash_read, flash_addr); end
    got = 1'b0; cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk); cyc++;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
  endtask

  task automatic test_busy_timeout;
    int   cyc = 0;
    logic got = 1'b0;
    repeat (2) @(negedge clk);
    model_timeout = 1'b1; model_data = 8'h3C; addr0 = 24'h000040; req0 = 1'b1;
    @(negedge clk);
    checks++; if (flash_read !== 1'b1) begin fails++; $display("FAIL timeout_strobe: got %b want 1", flash_read); end
    while (!got && cyc < 60) begin
      @(negedge clk); cyc++;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    checks++; if (!got || cyc != 10) begin fails++; $display("FAIL timeout_latency: got %0d (ack %b) want 10", cyc, got); end
    checks++; if (data0 !== 8'h3C) begin fails++; $display("FAIL timeout_data0: got %h want 3c", data0); end
    model_timeout = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int   cyc = 0;
    logic got = 1'b0, a0 = 1'b0;
    repeat (2) @(negedge clk);
    model_data = 8'h77; addr0 = 24'h000077; req0 = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (flash_addr !== 24'h0) begin fails++; $display("FAIL rstmid_flash_addr: got %h want 000000", flash_addr); end
    checks++; if (data0 !== 8'h00) begin fails++; $display("FAIL rstmid_data0: got %h want 00", data0); end
    checks++; if (flash_read !== 1'b0 || flash_pt !== 1'b0 || ack0 !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: read %b pt %b ack0 %b want 0 0 0", flash_read, flash_pt, ack0); end
    req0 = 1'b0;
    repeat (3) begin @(negedge clk); if (ack0) a0 = 1'b1; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); if (ack0) a0 = 1'b1; end
    checks++; if (a0 !== 1'b0) begin fails++; $display("FAIL rstmid_no_ack: got %b want 0", a0); end
    model_data = 8'h91; addr0 = 24'h000040; req0 = 1'b1;
    @(negedge clk);
    checks++; if (flash_read !== 1'b1 || flash_addr !== 24'h000040) begin fails++; $display("FAIL rstmid_fresh_read: strobe %b addr %h want 1 000040", flash_read, flash_addr); end
    while (!got && cyc < 30) begin
      @(negedge clk); cyc++;
      if (ack0) got = 1'b1;
    end
    req0 = 1'b0;
    checks++; if (!got || data0 !== 8'h91) begin fails++; $display("FAIL rstmid_data0_after: ack %b data %h want 1 91", got, data0); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_cache_hit();
    test_starvation();
    test_passthrough_during_read();
    test_busy_timeout();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/qpi_flash_arbiter.md
Name: qpi_flash_arbiter

Overview:
- Shares one qpi_flash read engine between two byte-read requesters and one SPI passthrough requester.
- Requesters: port 0 is the CPU ROM window; port 1 is the background copier/prefetcher; the passthrough requester is the host flash programmer.
- Sequences the engine's read pulse/ready handshake and keeps a one-entry last-byte cache.
- Sits between the bus glue and qpi_flash, on the engine side of all requesters.

Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 waits before port 1 is forced next; legal 1-15.
- BUSY_TIMEOUT, 8: cycles to wait for flash_ready to fall after a read pulse before treating the read as complete.

Ports:
- clk  in  1  system clock.
- reset_wait_finished  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 read request; held until ack0.
- addr0  in  24  port 0 byte address; stable while req0 is high.
- ack0  out  1  one-cycle pulse; data0 valid in the same cycle.
- data0  out  8  port 0 read data.
- req1, addr1, ack1, data1: same as port 0, for port 1.
- pt_req  in  1  passthrough request; level, held for the whole session.
- pt_gnt  out  1  passthrough granted; the programmer drives SPI only while this is high.
- flash_ready  in  1  qpi_flash ready.
- flash_read  out  1  one-cycle read strobe to qpi_flash.
- flash_addr  out  24  registered address to qpi_flash.
- flash_data  in  8  qpi_flash data_out; valid when ready returns high.
- flash_passthrough  out  1  qpi_flash passthrough enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; cache invalid; starvation counter 0; last_grant = port 0.
- Reset mid-operation: abandon the transaction. Emit no ack and do not update the cache. flash_read and flash_passthrough deassert asynchronously.
- States:
  - IDLE: evaluate requests each cycle while flash_ready=1. Priority: pt_req, then the cache-hit check, then the port arbiter.
  - HIT: taken when the winning port's address equals cache_addr and the cache is valid. Next cycle, pulse ack with cache_data, no flash access, return to IDLE. Total latency from req to ack: 2 cycles.
  - ISSUE: latch flash_addr, pulse flash_read for exactly 1 cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for flash_ready=0, then go to WAIT_DONE. If BUSY_TIMEOUT cycles pass with flash_ready still high, go to WAIT_DONE anyway.
  - WAIT_DONE: on flash_ready=1, capture flash_data into the granted port's data register and into the cache, then pulse ack. Return to IDLE the next cycle.
  - PT_ENTER: assert flash_passthrough, then pt_gnt the following cycle, and go to PASS.
  - PASS: hold both until pt_req=0. Then deassert pt_gnt, deassert flash_passthrough one cycle later, invalidate the cache, go to IDLE.
- Arbitration:
  - Fixed priority to port 0 by default.
  - The starvation counter increments on each port-0 grant while req1 is high. It clears on any port-1 grant or when req1 is low.
  - When the counter reaches STARVE_LIMIT, port 1 wins the next arbitration even if req0 is high.
  - Cache hits count as grants.
- Simultaneous events:
  - pt_req arriving during a read: wait for the read to complete; passthrough wins at the next IDLE over both ports.
  - A requester dropping req before ack is a protocol violation; the ack is still issued.
- At most one ack per cycle; ack0 and ack1 are never high together.
- A port cannot re-win on the cycle its ack is pulsed; its req is sampled again from the next IDLE.
- No new flash_read while flash_ready=0.

Decomposition:
- Package qpi_flash_pkg: state enum, ADDR_W=24, DATA_W=8, port index type.
- One sub-module, qpi_flash_rr_select: two-port priority selector with starvation counter. Outputs grant index and valid.

Test Plan:
- Single read: req0 with addr0=0x123454; model returns 0xAB. Required: flash_read pulse with flash_addr=0x123454, then ack0 with data0=0xAB, ack1 stays 0.
- Cache hit: repeat req0 with 0x123454 → ack0 exactly 2 cycles after req, data0=0xAB, no flash_read.
- Contention/starvation: req0 and req1 held continuously at different addresses, STARVE_LIMIT=4. Required grant order: 0,0,0,0,1,0,0,0,0,1…
- Passthrough during read: raise pt_req mid-read of 0x000005. Required: ack for that read first; flash_passthrough, then pt_gnt one cycle later. Drop pt_req → both deassert. Next read of the same address misses the cache (flash_read pulses).
- Busy timeout: the model never drops flash_ready after the strobe. Required: WAIT_DONE entered after 8 cycles; ack issued with the current flash_data.
- Reset during WAIT_DONE: assert reset_wait_finished → all outputs 0 immediately, no ack. After release, the next req0 issues a fresh flash_read (cache invalid).
